// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse tracker.
// Defining PS2_MOUSE_WHEEL_EN selects 4-byte IntelliMouse packets carrying a wheel delta.
package ps2_mouse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_B1,
        ST_B2,
        ST_B3,
        ST_APPLY
    } state_e;

    // Bit positions inside the first (header) byte of a packet.
    localparam int B0_L    = 0;
    localparam int B0_R    = 1;
    localparam int B0_M    = 2;
    localparam int B0_SYNC = 3;
    localparam int B0_XS   = 4;
    localparam int B0_YS   = 5;
    localparam int B0_XO   = 6;
    localparam int B0_YO   = 7;

    // Header fields kept after the sync bit has been checked.
    typedef struct packed {
        logic y_ovf;
        logic x_ovf;
        logic y_sign;
        logic x_sign;
        logic btn_m;
        logic btn_r;
        logic btn_l;
    } hdr_t;

`ifdef PS2_MOUSE_WHEEL_EN
    localparam int PKT_LEN = 4;
`else
    localparam int PKT_LEN = 3;
`endif

    // Scaled deltas are carried wide enough to hold the negation of -256.
    localparam int DELTA_W = 10;

endpackage

// File: rtl/ps2_axis_tracker.sv
// One cursor axis: clamped absolute accumulator plus a hysteresis bin stepper
// that moves the reported bin at most one step per cycle.
module ps2_axis_tracker
    import ps2_mouse_pkg::*;
#(
    parameter  int N_BINS     = 10,
    parameter  int BIN        = 100,
    parameter  int HYSTERESIS = 30,
    localparam int RANGE      = N_BINS * BIN,
    localparam int PW         = $clog2(RANGE),
    localparam int BW         = $clog2(N_BINS)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      recentre_i,
    input  logic                      delta_en_i,
    input  logic signed [DELTA_W-1:0] delta_i,
    output logic        [PW-1:0]      pos_o,
    output logic        [BW-1:0]      bin_o
);

    localparam int SW = ((PW > DELTA_W) ? PW : DELTA_W) + 2;
    localparam logic signed [SW-1:0] POS_MAX = SW'(RANGE - 1);
    localparam logic [PW-1:0] POS_CTR = PW'(RANGE / 2);
    localparam logic [BW-1:0] BIN_CTR = BW'(N_BINS / 2);
    localparam logic [BW-1:0] BIN_MAX = BW'(N_BINS - 1);

    logic        [PW-1:0] pos_q, pos_d;
    logic        [BW-1:0] bin_q, bin_d;
    logic signed [SW-1:0] sum;
    logic        [31:0]   pos_u, up_thr, dn_thr;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sum    = $signed({{(SW-PW){1'b0}}, pos_q}) +
                 $signed({{(SW-DELTA_W){delta_i[DELTA_W-1]}}, delta_i});
        pos_u  = 32'(pos_q);
        up_thr = (32'(bin_q) + 32'd1) * 32'(BIN) + 32'(HYSTERESIS);
        dn_thr = 32'(bin_q) * 32'(BIN);
        pos_d  = pos_q;
        bin_d  = bin_q;

        if (delta_en_i) begin
            if (sum < 0)            pos_d = '0;
            else if (sum > POS_MAX) pos_d = POS_MAX[PW-1:0];
            else                    pos_d = sum[PW-1:0];
        end

        if (pos_u >= up_thr && bin_q != BIN_MAX)                       bin_d = bin_q + 1'b1;
        else if (pos_u + 32'(HYSTERESIS) < dn_thr && bin_q != '0)     bin_d = bin_q - 1'b1;

        if (recentre_i) begin
            pos_d = POS_CTR;
            bin_d = BIN_CTR;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pos_q <= POS_CTR;
            bin_q <= BIN_CTR;
        end else begin
            pos_q <= pos_d;
            bin_q <= bin_d;
        end
    end

    assign pos_o = pos_q;
    assign bin_o = bin_q;

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse back end: packet assembly with resync and timeout, per-axis tracking.
// Defining PS2_MOUSE_WHEEL_EN adds a fourth packet byte and the saturating wheel output.
module ps2_mouse_tracker
    import ps2_mouse_pkg::*;
#(
    parameter int WIDTH       = 10,
    parameter int HEIGHT      = 10,
    parameter int BIN         = 100,
    parameter int HYSTERESIS  = 30,
    parameter int SCALE_SHIFT = 0,
    parameter int PKT_TIMEOUT = 50000
) (
    input  logic                            CLOCK_50,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic                            byte_valid,
    input  logic [7:0]                      byte_data,
    output logic                            button_left,
    output logic                            button_right,
    output logic                            button_middle,
    output logic [$clog2(WIDTH*BIN)-1:0]    pos_x,
    output logic [$clog2(HEIGHT*BIN)-1:0]   pos_y,
    output logic [$clog2(WIDTH)-1:0]        bin_x,
    output logic [$clog2(HEIGHT)-1:0]       bin_y,
    output logic                            pkt_valid,
    output logic                            sync_err
`ifdef PS2_MOUSE_WHEEL_EN
    ,
    output logic signed [7:0]               wheel
`endif
);

    localparam int TW = $clog2(PKT_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(PKT_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    hdr_t            hdr_q, hdr_d;
    logic [7:0]      byte1_q, byte1_d, byte2_q, byte2_d;
    logic            sync_err_q, sync_err_d, pkt_valid_q;
    logic [2:0]      btn_q;
    logic            apply;

    assign apply = (state_q == ST_APPLY);

`ifdef PS2_MOUSE_WHEEL_EN
    logic        [3:0] byte3_q, byte3_d;
    logic signed [7:0] wheel_q;
    logic signed [8:0] wheel_sum;
    assign wheel_sum = $signed({wheel_q[7], wheel_q}) + $signed({{5{byte3_q[3]}}, byte3_q});
    assign wheel     = wheel_q;
`endif

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        sync_err_d = 1'b0;
        hdr_d      = hdr_q;
        byte1_d    = byte1_q;
        byte2_d    = byte2_q;
`ifdef PS2_MOUSE_WHEEL_EN
        byte3_d    = byte3_q;
`endif

        if (byte_valid) begin
            tmo_d = '0;
        end else if (state_q inside {ST_B1, ST_B2, ST_B3}) begin
            if (tmo_q == TMO_LAST) begin
                state_d    = ST_IDLE;
                sync_err_d = 1'b1;
                tmo_d      = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: if (byte_valid) begin
                if (byte_data[B0_SYNC]) begin
                    hdr_d   = '{y_ovf: byte_data[B0_YO], x_ovf: byte_data[B0_XO],
                                y_sign: byte_data[B0_YS], x_sign: byte_data[B0_XS],
                                btn_m: byte_data[B0_M], btn_r: byte_data[B0_R],
                                btn_l: byte_data[B0_L]};
                    state_d = ST_B1;
                end else begin
                    sync_err_d = 1'b1;
                end
            end
            ST_B1: if (byte_valid) begin
                byte1_d = byte_data;
                state_d = ST_B2;
            end
            ST_B2: if (byte_valid) begin
                byte2_d = byte_data;
                state_d = (PKT_LEN == 4) ? ST_B3 : ST_APPLY;
            end
`ifdef PS2_MOUSE_WHEEL_EN
            ST_B3: if (byte_valid) begin
                byte3_d = byte_data[3:0];
                state_d = ST_APPLY;
            end
`endif
            ST_APPLY: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            sync_err_q  <= 1'b0;
            pkt_valid_q <= 1'b0;
            btn_q       <= '0;
`ifdef PS2_MOUSE_WHEEL_EN
            wheel_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            sync_err_q  <= sync_err_d;
            pkt_valid_q <= apply;
            if (apply) begin
                btn_q <= {hdr_q.btn_m, hdr_q.btn_r, hdr_q.btn_l};
`ifdef PS2_MOUSE_WHEEL_EN
                if (wheel_sum > 9'sd127)       wheel_q <= 8'sd127;
                else if (wheel_sum < -9'sd128) wheel_q <= -8'sd128;
                else                           wheel_q <= wheel_sum[7:0];
`endif
            end
        end
    end

    // NOTE: packet byte registers have no reset; each is rewritten before APPLY reads it.
    always_ff @(posedge CLOCK_50) begin
        hdr_q   <= hdr_d;
        byte1_q <= byte1_d;
        byte2_q <= byte2_d;
`ifdef PS2_MOUSE_WHEEL_EN
        byte3_q <= byte3_d;
`endif
    end

    logic signed [8:0]         dx_s, dy_s;
    logic signed [DELTA_W-1:0] dx, dy_neg;

    // Y is negated so that PS/2 "up" moves toward row 0.
    assign dx_s   = $signed({hdr_q.x_sign, byte1_q}) >>> SCALE_SHIFT;
    assign dy_s   = $signed({hdr_q.y_sign, byte2_q}) >>> SCALE_SHIFT;
    assign dx     = $signed({dx_s[8], dx_s});
    assign dy_neg = -$signed({dy_s[8], dy_s});

    ps2_axis_tracker #(.N_BINS(WIDTH), .BIN(BIN), .HYSTERESIS(HYSTERESIS)) u_axis_x (
        .clk_i      (CLOCK_50),
        .rst_ni     (reset_n),
        .recentre_i (start),
        .delta_en_i (apply && !hdr_q.x_ovf),
        .delta_i    (dx),
        .pos_o      (pos_x),
        .bin_o      (bin_x)
    );

    ps2_axis_tracker #(.N_BINS(HEIGHT), .BIN(BIN), .HYSTERESIS(HYSTERESIS)) u_axis_y (
        .clk_i      (CLOCK_50),
        .rst_ni     (reset_n),
        .recentre_i (start),
        .delta_en_i (apply && !hdr_q.y_ovf),
        .delta_i    (dy_neg),
        .pos_o      (pos_y),
        .bin_o      (bin_y)
    );

    assign button_left   = btn_q[0];
    assign button_right  = btn_q[1];
    assign button_middle = btn_q[2];
    assign pkt_valid     = pkt_valid_q;
    assign sync_err      = sync_err_q;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Self-checking bench for ps2_mouse_tracker: directed scenarios plus random packets,
// all compared every cycle against a packet-level behavioural model.
module tb_ps2_mouse_tracker;

    localparam int WIDTH  = 10;
    localparam int HEIGHT = 10;
    localparam int BIN    = 100;
    localparam int HYST   = 30;
    localparam int SHIFT  = 0;
    localparam int TMO    = 50000;
    localparam int XR     = WIDTH * BIN;
    localparam int YR     = HEIGHT * BIN;
    localparam int SETTLE = ((WIDTH > HEIGHT) ? WIDTH : HEIGHT) + 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic button_left, button_right, button_middle, pkt_valid, sync_err;
    logic [$clog2(XR)-1:0]     pos_x;
    logic [$clog2(YR)-1:0]     pos_y;
    logic [$clog2(WIDTH)-1:0]  bin_x;
    logic [$clog2(HEIGHT)-1:0] bin_y;
`ifdef PS2_MOUSE_WHEEL_EN
    logic signed [7:0] wheel;
`endif

    ps2_mouse_tracker #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BIN(BIN), .HYSTERESIS(HYST),
        .SCALE_SHIFT(SHIFT), .PKT_TIMEOUT(TMO)
    ) dut (
        .CLOCK_50      (clk),
        .reset_n       (reset_n),
        .start         (start),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .button_left   (button_left),
        .button_right  (button_right),
        .button_middle (button_middle),
        .pos_x         (pos_x),
        .pos_y         (pos_y),
        .bin_x         (bin_x),
        .bin_y         (bin_y),
        .pkt_valid     (pkt_valid),
        .sync_err      (sync_err)
`ifdef PS2_MOUSE_WHEEL_EN
        ,
        .wheel         (wheel)
`endif
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model state (packet-level).
    int m_x, m_y, m_bx, m_by, m_btn, m_wheel;
    int last_move = 0;
    int exp_pkt_cyc = -1;
    int exp_sync_cyc = -1;
    bit chk_on = 1'b0;
    bit tmo_mode = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int clamp(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    // Bin the tracker settles to from a starting bin once the position stops moving.
    function automatic int settle(input int pos, input int bin, input int nb);
        int b = bin;
        for (int k = 0; k < nb + 2; k++) begin
            if (pos >= (b + 1) * BIN + HYST && b < nb - 1) b++;
            else if (pos + HYST < b * BIN && b > 0)        b--;
        end
        return b;
    endfunction

    task automatic model_reset();
        m_x = XR / 2;  m_y = YR / 2;
        m_bx = WIDTH / 2;  m_by = HEIGHT / 2;
        m_btn = 0;  m_wheel = 0;
        exp_pkt_cyc = -1;  exp_sync_cyc = -1;
    endtask

    task automatic model_apply(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        int dx, dy, w;
        dx = b0[4] ? int'(b1) - 256 : int'(b1);
        dy = b0[5] ? int'(b2) - 256 : int'(b2);
        dx = dx >>> SHIFT;
        dy = dy >>> SHIFT;
        if (!b0[6]) m_x = clamp(m_x + dx, XR - 1);
        if (!b0[7]) m_y = clamp(m_y - dy, YR - 1);
        m_bx = settle(m_x, m_bx, WIDTH);
        m_by = settle(m_y, m_by, HEIGHT);
        m_btn = int'(b0[2:0]);
        w = b3[3] ? int'(b3[3:0]) - 16 : int'(b3[3:0]);
        m_wheel = (m_wheel + w > 127) ? 127 : ((m_wheel + w < -128) ? -128 : m_wheel + w);
        last_move = cyc + 1;
    endtask

    // Compare process: every cycle, just after the active edge.
    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            check("pkt_valid", int'(pkt_valid), int'(cyc == exp_pkt_cyc));
            if (!tmo_mode) check("sync_err", int'(sync_err), int'(cyc == exp_sync_cyc));
            check("button_left", int'(button_left), m_btn & 1);
            check("button_right", int'(button_right), (m_btn >> 1) & 1);
            check("button_middle", int'(button_middle), (m_btn >> 2) & 1);
            check("pos_x", int'(pos_x), m_x);
            check("pos_y", int'(pos_y), m_y);
            if (cyc > last_move + SETTLE) begin
                check("bin_x", int'(bin_x), m_bx);
                check("bin_y", int'(bin_y), m_by);
            end
`ifdef PS2_MOUSE_WHEEL_EN
            check("wheel", int'(wheel), m_wheel);
`endif
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit drop);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        if (drop) exp_sync_cyc = cyc + 1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Returns one negedge after the APPLY edge, i.e. with the packet's effect visible.
    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3, input int gap);
        send_byte(b0, 1'b0);  idle(gap);
        send_byte(b1, 1'b0);  idle(gap);
        send_byte(b2, 1'b0);
`ifdef PS2_MOUSE_WHEEL_EN
        idle(gap);
        send_byte(b3, 1'b0);
`endif
        model_apply(b0, b1, b2, b3);
        exp_pkt_cyc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset_n = 1'b0;  start = 1'b0;  byte_valid = 1'b0;
        model_reset();
        repeat (n) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk);
        start = 1'b1;
        m_x = XR / 2;  m_y = YR / 2;  m_bx = WIDTH / 2;  m_by = HEIGHT / 2;
        repeat (n) @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, pulses, c0;
        logic [7:0] b0;

        // 1. Reset and release.
        model_reset();
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        reset_n = 1'b1;
        idle(2);
        check("rst_pos_x", int'(pos_x), 500);
        check("rst_pos_y", int'(pos_y), 500);
        check("rst_bin_x", int'(bin_x), 5);
        check("rst_bin_y", int'(bin_y), 5);
        check("rst_buttons", int'({button_middle, button_right, button_left}), 0);
        check("rst_pkt_valid", int'(pkt_valid), 0);

        // 2. Small move with left button, then a move across the hysteresis edge.
        send_packet(8'h09, 8'h32, 8'h00, 8'h00, 1);
        check("t2_pkt_valid", int'(pkt_valid), 1);
        check("t2_left", int'(button_left), 1);
        check("t2_pos_x", int'(pos_x), 550);
        idle(SETTLE);
        check("t2_bin_x", int'(bin_x), 5);
        send_packet(8'h08, 8'h50, 8'h00, 8'h00, 1);
        check("t2_pos_x_630", int'(pos_x), 630);
        idle(1);
        check("t2_bin_x_6_fast", int'(bin_x), 6);
        idle(SETTLE);

        // 3. Move back inside the hysteresis band, then beyond it.
        send_packet(8'h18, 8'hEC, 8'h00, 8'h00, 0);
        check("t3_pos_x_610", int'(pos_x), 610);
        idle(SETTLE);
        send_packet(8'h18, 8'hEC, 8'h00, 8'h00, 2);
        check("t3_pos_x_590", int'(pos_x), 590);
        idle(SETTLE);
        check("t3_bin_x_hold", int'(bin_x), 6);
        send_packet(8'h18, 8'hE2, 8'h00, 8'h00, 1);
        check("t3_pos_x_560", int'(pos_x), 560);
        idle(SETTLE);
        check("t3_bin_x_5", int'(bin_x), 5);

        // 4. Downward move (dy = -50), then saturate X at the right edge.
        send_packet(8'h28, 8'h00, 8'hCE, 8'h00, 1);
        check("t4_pos_y_550", int'(pos_y), 550);
        idle(SETTLE);
        check("t4_bin_y", int'(bin_y), 5);
        for (int i = 0; i < 10; i++) begin
            send_packet(8'h08, 8'hFF, 8'h00, 8'h00, 0);
            idle(SETTLE);
        end
        check("t4_pos_x_clamp", int'(pos_x), 999);
        check("t4_bin_x_max", int'(bin_x), 9);

        // 5. Stray byte in IDLE, normal packet, X-overflow packet.
        pulse_start(2);
        idle(2);
        send_byte(8'h00, 1'b1);
        idle(3);
        send_packet(8'h08, 8'h10, 8'h00, 8'h00, 1);
        check("t5_pos_x_516", int'(pos_x), 516);
        idle(SETTLE);
        send_packet(8'h48, 8'h10, 8'h00, 8'h00, 1);
        check("t5_ovf_pkt_valid", int'(pkt_valid), 1);
        check("t5_ovf_pos_x", int'(pos_x), 516);
        idle(SETTLE);

        // 6. Inter-byte timeout after a lone header byte.
        tmo_mode = 1'b1;
        send_byte(8'h08, 1'b0);
        c0 = cyc;
        first = -1;
        pulses = 0;
        for (int k = 0; k < TMO + 20; k++) begin
            @(posedge clk);
            #1;
            if (sync_err) begin
                pulses++;
                if (first < 0) first = cyc - c0;
            end
        end
        check("t6_tmo_in_window", int'(first >= TMO - 1 && first <= TMO + 1), 1);
        check("t6_tmo_pulses", pulses, 1);
        tmo_mode = 1'b0;
        idle(2);
        send_packet(8'h0A, 8'h00, 8'h00, 8'h00, 1);
        check("t6_right", int'(button_right), 1);
        check("t6_left", int'(button_left), 0);
        check("t6_pos_x", int'(pos_x), 516);
        check("t6_pos_y", int'(pos_y), 500);
        idle(SETTLE);

        // 7. Reset in the middle of a packet discards it.
        send_byte(8'h08, 1'b0);
        send_byte(8'h40, 1'b0);
        do_reset(2);
        idle(2);
        send_packet(8'h08, 8'h05, 8'h00, 8'h00, 1);
        check("t7_pos_x_505", int'(pos_x), 505);
        check("t7_right", int'(button_right), 0);
        idle(SETTLE);

        // 8. Random packets, stray bytes and recentres.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                send_byte(8'($urandom) & 8'hF7, 1'b1);
                idle($urandom_range(1, 3));
            end
            if ($urandom_range(0, 14) == 0) begin
                pulse_start($urandom_range(1, 3));
                idle(2);
            end
            b0 = 8'($urandom);
            b0[3] = 1'b1;
            b0[6] = ($urandom_range(0, 3) == 0);
            b0[7] = ($urandom_range(0, 3) == 0);
            send_packet(b0, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3));
            idle(SETTLE + $urandom_range(0, 5));
        end

        idle(4);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
